// File: rtl/aes_pkg.sv
// aes_pkg: shared encodings, FSM state type and defaults for the AES round controller
package aes_pkg;
  localparam int NR_DEFAULT = 10;
  typedef enum logic [1:0] {SEL_ARK = 2'd0, SEL_SUB = 2'd1, SEL_SHIFT = 2'd2, SEL_MIX = 2'd3} stage_sel_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;
endpackage

// File: rtl/aes_stage_seq.sv
// aes_stage_seq: next stage/round after the current one, plus final-stage flag
module aes_stage_seq import aes_pkg::*; #(
  parameter int NR = NR_DEFAULT
) (
  input  stage_sel_e sel_i,
  input  logic [3:0] round_i,
  output stage_sel_e sel_o,
  output logic [3:0] round_o,
  output logic       last_o
);
  logic final_rnd;
  assign final_rnd = round_i == 4'(NR);
  assign last_o = sel_i == SEL_ARK && final_rnd;
  // round only advances on the ARK -> SUB step, and saturates at NR
  assign round_o = (sel_i == SEL_ARK && !final_rnd) ? round_i + 4'd1 : round_i;
  assign sel_o = sel_i == SEL_ARK ? SEL_SUB :
                 sel_i == SEL_SUB ? SEL_SHIFT :
                 (sel_i == SEL_SHIFT && !final_rnd) ? SEL_MIX : SEL_ARK;
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences the 4*NR AES stages of one block through an external round datapath
module aes_round_ctrl import aes_pkg::*; #(
  parameter int NR      = NR_DEFAULT,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         stage_start,
  output logic [1:0]   stage_sel,
  output logic [3:0]   round,
  output logic [127:0] stage_state,
  input  logic         stage_finish,
  input  logic [127:0] stage_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic         error
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_e       state_q, state_d;
  stage_sel_e   sel_q, sel_d, sel_nx;
  logic [3:0]   round_q, round_d, round_nx;
  logic [127:0] data_q, data_d;
  logic [WW-1:0] wd_q, wd_d;
  logic         error_q, error_d, last;
  aes_stage_seq #(.NR(NR)) u_seq (
    .sel_i(sel_q), .round_i(round_q), .sel_o(sel_nx), .round_o(round_nx), .last_o(last)
  );
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    round_d = round_q;
    data_d  = data_q;
    wd_d    = wd_q;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE:
        if (in_valid && key_valid) begin
          state_d = ST_ISSUE;
          sel_d   = SEL_ARK;
          round_d = '0;
          data_d  = in_block;
        end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wd_d    = '0;
      end
      ST_WAIT:
        if (stage_finish) begin
          state_d = last ? ST_DONE : ST_ISSUE;
          data_d  = stage_result;
          sel_d   = last ? sel_q : sel_nx;
          round_d = last ? round_q : round_nx;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      default:
        if (out_ready) state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_ARK;
      round_q <= '0;
      data_q  <= '0;
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      round_q <= round_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end
  assign in_ready    = state_q == ST_IDLE && key_valid;
  assign stage_start = state_q == ST_ISSUE;
  assign stage_sel   = sel_q;
  assign round       = round_q;
  assign stage_state = data_q;
  assign out_valid   = state_q == ST_DONE;
  assign out_block   = out_valid ? data_q : '0;
  assign busy        = state_q != ST_IDLE;
  assign error       = error_q;
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of cipher rounds (legal values 10, 12, 14).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum WAIT cycles allowed before stage_finish.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port key_valid  input  1  expanded key is stable and usable.
REQ-006 SHALL have port in_valid  input  1  a plaintext block is offered.
REQ-007 SHALL have port in_ready  output  1  controller accepts a block.
REQ-008 SHALL have port in_block  input  128  plaintext block.
REQ-009 SHALL have port stage_start  output  1  one-cycle start pulse to the round datapath.
REQ-010 SHALL have port stage_sel  output  2  selected operation: 0 ARK, 1 SUB, 2 SHIFT, 3 MIX.
REQ-011 SHALL have port round  output  4  current round number, driven to the addroundkey key index.
REQ-012 SHALL have port stage_state  output  128  state presented to the datapath.
REQ-013 SHALL have port stage_finish  input  1  datapath result valid.
REQ-014 SHALL have port stage_result  input  128  datapath result.
REQ-015 SHALL have port out_valid  output  1  ciphertext is available.
REQ-016 SHALL have port out_ready  input  1  consumer accepts the ciphertext.
REQ-017 SHALL have port out_block  output  128  ciphertext.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.
REQ-019 SHALL have port error  output  1  one-cycle pulse on a stage timeout.

Function
REQ-020 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-021 in_ready SHALL equal (state==IDLE && key_valid); on in_valid&&in_ready: latch in_block, round=0, stage_sel=ARK, go to ISSUE.
REQ-022 The stage order SHALL be: round 0 ARK; rounds 1..NR-1 SUB, SHIFT, MIX, ARK; round NR SUB, SHIFT, ARK (no MIX); 4*NR stages in total.
REQ-023 ISSUE SHALL assert stage_start for exactly one cycle with stage_sel, round and stage_state stable, then go to WAIT.
REQ-024 stage_sel, round and stage_state SHALL hold constant from ISSUE until the corresponding finish is sampled.
REQ-025 In WAIT, stage_finish SHALL load stage_result into the state register and advance the stage; the next state is ISSUE, or DONE after the final ARK.
REQ-026 stage_finish SHALL be ignored outside WAIT, including in the ISSUE cycle itself.
REQ-027 round SHALL increment only when moving from ARK to the next SUB, and SHALL never exceed NR.
REQ-028 DONE SHALL assert out_valid with out_block equal to the state register, holding both until out_ready; on out_valid&&out_ready the FSM SHALL go to IDLE.
REQ-029 A watchdog counter SHALL clear on entry to WAIT; if TIMEOUT cycles elapse without stage_finish, the block SHALL pulse error, drop the block and go to IDLE.
REQ-030 key_valid falling mid-block SHALL NOT abort the block; it gates only new acceptance.
REQ-031 With a datapath that asserts finish on the first WAIT cycle, out_valid SHALL rise exactly 8*NR cycles after the input handshake edge.

Reset
REQ-032 rst SHALL asynchronously force the FSM to IDLE and clear round, stage_sel, stage_start, stage_state, out_valid, out_block, error and the watchdog, all to 0.
REQ-033 Reset asserted mid-block SHALL discard the block with no out_valid; in_ready SHALL follow key_valid from the first cycle after release.

Structure
REQ-034 The shared package aes_pkg SHALL hold the stage_sel encodings, the FSM state type and the default NR.
REQ-035 The stage/round stepping logic (next stage_sel, next round, last-stage flag) SHALL be one sub-module, aes_stage_seq; the FSM, watchdog and registers SHALL stay in aes_round_ctrl.

Verification
REQ-036 Bench SHALL cover: FIPS-197 plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, behavioural stage model -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, 40 stage_start pulses, out_valid at +80 cycles.
REQ-037 Bench SHALL cover: stage sequence log -> round 0 ARK only, round 10 has no MIX, round never exceeds 10.
REQ-038 Bench SHALL cover: out_ready held low 5 cycles -> out_valid and out_block stable; in_ready stays 0 until handshake.
REQ-039 Bench SHALL cover: model withholds finish in round 3 -> error pulse after 16 WAIT cycles, IDLE, then next block completes correctly.
REQ-040 Bench SHALL cover: rst asserted in round 5 -> all outputs 0 immediately, no out_valid; key_valid=0 -> in_ready=0 despite in_valid=1.
